// File: rtl/demux_stream_1to2_if.sv
// Stream bundle for the 1:2 demux: one valid/ready input with select, two valid/ready outputs.
// slave = demux side, master = producer/consumers side.
interface demux_stream_1to2_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         s;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out0_data;
  logic         out0_last;
  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] out1_data;
  logic         out1_last;

  modport slave (
    input  in_valid, in_data, in_last, s, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );

  modport master (
    output in_valid, in_data, in_last, s, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );
endinterface

// File: rtl/demux_stream_1to2.sv
// Registered 1:2 packet demux, select locked per packet; 1-cycle latency, in_ready = free(target).
// DEMUX_STATS_EN adds per-output delivered-beat counters cnt0/cnt1 (CNT_W bits, wrapping).
module demux_stream_1to2 #(
  parameter int W = 8
`ifdef DEMUX_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_stream_1to2_if.slave     bus
`ifdef DEMUX_STATS_EN
  , output logic [CNT_W-1:0]     cnt0
  , output logic [CNT_W-1:0]     cnt1
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]   state;
  logic         tgt;
  logic         free0, free1;
  logic         acc, fill0, fill1;
  logic         v0, v1, l0, l1;
  logic [W-1:0] d0, d1;

  always_comb begin
    tgt = bus.s;
    case (state)
      LOCK0:   tgt = 1'b0;
      LOCK1:   tgt = 1'b1;
      default: tgt = bus.s;
    endcase
  end

  assign free0 = !v0 || bus.out0_ready;
  assign free1 = !v1 || bus.out1_ready;

  // rst_n gates in_ready so the producer sees no accept while reset is asserted
  assign bus.in_ready = rst_n && (tgt ? free1 : free0);
  assign acc          = bus.in_valid && bus.in_ready;
  assign fill0        = acc && !tgt;
  assign fill1        = acc && tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (acc) begin
      if (bus.in_last)
        state <= IDLE;
      else if (state == IDLE)
        state <= bus.s ? LOCK1 : LOCK0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      d0 <= '0;
      l0 <= 1'b0;
    end else if (fill0) begin
      v0 <= 1'b1;
      d0 <= bus.in_data;
      l0 <= bus.in_last;
    end else if (v0 && bus.out0_ready) begin
      v0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
      l1 <= 1'b0;
    end else if (fill1) begin
      v1 <= 1'b1;
      d1 <= bus.in_data;
      l1 <= bus.in_last;
    end else if (v1 && bus.out1_ready) begin
      v1 <= 1'b0;
    end
  end

  assign bus.out0_valid = v0;
  assign bus.out0_data  = d0;
  assign bus.out0_last  = l0;
  assign bus.out1_valid = v1;
  assign bus.out1_data  = d1;
  assign bus.out1_last  = l1;

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (v0 && bus.out0_ready) cnt0 <= cnt0 + 1'b1;
      if (v1 && bus.out1_ready) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream_1to2.sv
// Scoreboard bench for demux_stream_1to2: driver pushes expected beats per port, monitor pops on output handshakes.
module tb_demux_stream_1to2;
  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  logic [8:0] exp0[$];
  logic [8:0] exp1[$];

  demux_stream_1to2_if #(.W(8)) bus ();

`ifdef DEMUX_STATS_EN
  logic [3:0] cnt0, cnt1;
  demux_stream_1to2 #(.W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .cnt0(cnt0), .cnt1(cnt1)
  );
`else
  demux_stream_1to2 #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: every output handshake must match the head of that port's queue
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out0_valid && bus.out0_ready) begin
        if (exp0.size() == 0) begin
          total++;
          $display("FAIL out0_spurious: got beat %0h, expected none at %0t", {bus.out0_last, bus.out0_data}, $time);
        end else begin
          e = exp0.pop_front();
          chk("out0_beat", {23'd0, bus.out0_last, bus.out0_data}, {23'd0, e});
        end
      end
      if (rst_n && bus.out1_valid && bus.out1_ready) begin
        if (exp1.size() == 0) begin
          total++;
          $display("FAIL out1_spurious: got beat %0h, expected none at %0t", {bus.out1_last, bus.out1_data}, $time);
        end else begin
          e = exp1.pop_front();
          chk("out1_beat", {23'd0, bus.out1_last, bus.out1_data}, {23'd0, e});
        end
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted the beat.
  task automatic send_beat(input logic sel, input logic [7:0] d, input logic lst,
                           input logic port, input logic nostall);
    int waited = 0;
    bus.s        = sel;
    bus.in_data  = d;
    bus.in_last  = lst;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (nostall) chk("no_stall", waited, 0);
    if (!bus.in_ready) chk("accept_timeout", {31'd0, bus.in_ready}, 1);
    else if (port) exp1.push_back({lst, d});
    else exp0.push_back({lst, d});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out0_valid", {31'd0, bus.out0_valid}, 0);
    chk("rst_out1_valid", {31'd0, bus.out1_valid}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.s          = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    #1;
    chk("por_out0_valid", {31'd0, bus.out0_valid}, 0);
    chk("por_out1_valid", {31'd0, bus.out1_valid}, 0);
    chk("por_in_ready", {31'd0, bus.in_ready}, 0);
    chk("por_out0_data", {24'd0, bus.out0_data}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Mid-packet reset: lock to out1 with a stalled beat, then reset mid-cycle
    bus.s = 1'b1; bus.in_data = 8'h31; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.s = 1'b0; bus.in_data = 8'h32;
    @(negedge clk);
    chk("lock1_stall_in_ready", {31'd0, bus.in_ready}, 0);
    chk("lock1_out1_data", {24'd0, bus.out1_data}, 32'h31);
    #1;
    bus.out1_ready = 1'b1;
    #1;
    chk("lock1_in_ready_free", {31'd0, bus.in_ready}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", {31'd0, bus.in_ready}, 0);
    chk("async_out1_valid", {31'd0, bus.out1_valid}, 0);
    chk("async_out1_data", {24'd0, bus.out1_data}, 0);
    chk("async_out1_last", {31'd0, bus.out1_last}, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out0_ready = 1'b1;
    // FSM must be back in IDLE: s=0 routes to out0
    send_beat(1'b0, 8'h40, 1'b1, 1'b0, 1'b1);

    // Single beat to out1 with 1-cycle latency
    send_beat(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("single_out1_valid", {31'd0, bus.out1_valid}, 1);
    chk("single_out0_valid", {31'd0, bus.out0_valid}, 0);
    @(posedge clk);
    #1;

    // Packet lock: s toggles after the first beat, every beat stays on out0
    send_beat(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    send_beat(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    send_beat(1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
    send_beat(1'b1, 8'h04, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Backpressure on out0: held data, then drain and refill in one cycle
    bus.out0_ready = 1'b0;
    send_beat(1'b0, 8'h11, 1'b1, 1'b0, 1'b1);
    bus.s = 1'b0; bus.in_data = 8'h22; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 0);
      chk("bp_out0_data", {24'd0, bus.out0_data}, 32'h11);
    end
    @(posedge clk);
    #1;
    bus.out0_ready = 1'b1;
    send_beat(1'b0, 8'h22, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("refill_out0_valid", {31'd0, bus.out0_valid}, 1);
    @(posedge clk);
    #1;

    // Independence: out1 stalled on 3C while a new packet flows to out0
    bus.out1_ready = 1'b0;
    send_beat(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    send_beat(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    send_beat(1'b0, 8'h5B, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("indep_out1_valid", {31'd0, bus.out1_valid}, 1);
    chk("indep_out1_data", {24'd0, bus.out1_data}, 32'h3C);
    @(posedge clk);
    #1;
    bus.out1_ready = 1'b1;
    idle(3);

`ifdef DEMUX_STATS_EN
    apply_reset();
    for (int i = 0; i < 17; i++) send_beat(1'b0, 8'(i), 1'b1, 1'b0, 1'b1);
    idle(2);
    chk("cnt0_wrap", {28'd0, cnt0}, 1);
    chk("cnt1_zero", {28'd0, cnt1}, 0);
    bus.out1_ready = 1'b0;
    bus.s = 1'b1; bus.in_data = 8'h77; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    apply_reset();
    chk("stats_rst_cnt0", {28'd0, cnt0}, 0);
    chk("stats_rst_cnt1", {28'd0, cnt1}, 0);
    bus.out1_ready = 1'b1;
    send_beat(1'b0, 8'h66, 1'b1, 1'b0, 1'b1);
    idle(3);
`else
    apply_reset();
    send_beat(1'b0, 8'h66, 1'b1, 1'b0, 1'b1);
    idle(3);
`endif

    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
